// File: rtl/fir_io_pkg.sv
// Shared definitions for the FIR output path.
// Holds the output FSM state encoding, the host byte width and the default
// FIR result width used by both the FIR core and the result reader.
package fir_io_pkg;

  localparam int BYTE_W    = 8;
  localparam int FIR_OUT_W = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous FIFO that buffers FIR results ahead of the byte streamer.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   push, wdata     - write strobe and data (caller gates push against full)
//   pop, rdata      - read strobe (caller gates against empty); rdata shows the head
//   full, empty     - occupancy flags
//   count           - number of stored words
// The extra pointer MSB separates full from empty when the slot indices match.
module fir_sample_fifo #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fir_result_reader.sv
// Captures signed FIR results, buffers them and streams each one to the host
// as two bytes (low byte, then sign-extended high byte) over valid/ack.
// Ports:
//   clk, rst_n                - clock, synchronous active-low reset
//   y_n, y_valid              - FIR result and its one-cycle capture strobe
//   byte_out, byte_is_high    - presented byte and which half it is
//   byte_valid, byte_ack      - host handshake; transfer on valid && ack
//   fifo_count                - words waiting in the FIFO (not the output word)
//   overflow, ovf_clr         - sticky drop flag and its clear
//
// state   | meaning
// IDLE    | nothing to send, waiting for the FIFO to hold a word
// LO      | presenting low byte of word_q
// HI      | presenting sign-extended high byte of word_q
module fir_result_reader
  import fir_io_pkg::*;
#(
  parameter int DATA_W     = FIR_OUT_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             y_n,
  input  logic                          y_valid,
  output logic [BYTE_W-1:0]             byte_out,
  output logic                          byte_valid,
  output logic                          byte_is_high,
  input  logic                          byte_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  rd_state_e          state_q;
  logic [DATA_W-1:0]  word_q;
  logic [BYTE_W-1:0]  byte_out_q;
  logic               byte_valid_q;
  logic               byte_is_high_q;
  logic               overflow_q;
  logic               overflow_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W-1:0]  fifo_rdata;

  logic signed [DATA_W-1:0] word_s;
  logic [BYTE_W-1:0]        hi_byte;

  // Arithmetic shift keeps the sign, so the low 8 bits of the shifted word
  // are exactly the high byte sign-extended to 8 bits.
  assign word_s  = word_q;
  assign hi_byte = BYTE_W'(word_s >>> 8);

  // A pop happens whenever the FSM takes a new word: from IDLE, or at the end
  // of a high-byte transfer (back-to-back, no bubble).
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == ST_IDLE) || ((state_q == ST_HI) && byte_ack));
  // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
  assign fifo_push = y_valid && (!fifo_full || fifo_pop);

  always_comb begin
    overflow_d = overflow_q;
    if (y_valid && !fifo_push) overflow_d = 1'b1;
    else if (ovf_clr)          overflow_d = 1'b0;
  end

  fir_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (y_n),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      word_q         <= '0;
      byte_out_q     <= '0;
      byte_valid_q   <= 1'b0;
      byte_is_high_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            word_q         <= fifo_rdata;
            byte_out_q     <= fifo_rdata[BYTE_W-1:0];
            byte_valid_q   <= 1'b1;
            byte_is_high_q <= 1'b0;
            state_q        <= ST_LO;
          end
        end
        ST_LO: begin
          if (byte_ack) begin
            byte_out_q     <= hi_byte;
            byte_is_high_q <= 1'b1;
            state_q        <= ST_HI;
          end
        end
        ST_HI: begin
          if (byte_ack) begin
            if (fifo_pop) begin
              word_q         <= fifo_rdata;
              byte_out_q     <= fifo_rdata[BYTE_W-1:0];
              byte_is_high_q <= 1'b0;
              state_q        <= ST_LO;
            end else begin
              byte_out_q     <= '0;
              byte_valid_q   <= 1'b0;
              byte_is_high_q <= 1'b0;
              state_q        <= ST_IDLE;
            end
          end
        end
        default: begin
          byte_out_q     <= '0;
          byte_valid_q   <= 1'b0;
          byte_is_high_q <= 1'b0;
          state_q        <= ST_IDLE;
        end
      endcase
    end
  end

  assign byte_out     = byte_out_q;
  assign byte_valid   = byte_valid_q;
  assign byte_is_high = byte_is_high_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_fir_result_reader.sv
module tb_fir_result_reader;
  import fir_io_pkg::*;

  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] y_n;
  logic          y_valid;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_is_high;
  logic          byte_ack;
  logic [2:0]    fifo_count;
  logic          overflow;
  logic          ovf_clr;

  int errors = 0;
  int checks = 0;

  // expected bytes in transfer order: {is_high, byte}
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  fir_result_reader #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .y_n          (y_n),
    .y_valid      (y_valid),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_is_high (byte_is_high),
    .byte_ack     (byte_ack),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  function automatic logic [7:0] hi_of(input logic [DW-1:0] w);
    return {{(16-DW){w[DW-1]}}, w[DW-1:8]};
  endfunction

  task automatic expect_word(input logic [DW-1:0] w);
    exp_q.push_back({1'b0, w[7:0]});
    exp_q.push_back({1'b1, hi_of(w)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a byte moves whenever valid && ack is seen ahead of a rising edge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && byte_valid && byte_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got hi=%0b byte=%02h, expected none", byte_is_high, byte_out);
      end else begin
        e = exp_q.pop_front();
        if ({byte_is_high, byte_out} !== e) begin
          errors++;
          $display("FAIL byte_stream: got hi=%0b byte=%02h, expected hi=%0b byte=%02h",
                   byte_is_high, byte_out, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || byte_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes left, byte_valid=%0b, expected 0 and 0", exp_q.size(), byte_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; y_valid = 1'b1; y_n = 14'h1234; byte_ack = 1'b1; ovf_clr = 1'b0;
    step();
    step();
    @(negedge clk);
    checks++; if (byte_out !== 8'h00)   begin errors++; $display("FAIL reset_byte_out: got %02h expected 00", byte_out); end
    checks++; if (byte_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %0b expected 0", byte_valid); end
    checks++; if (byte_is_high !== 1'b0) begin errors++; $display("FAIL reset_is_high: got %0b expected 0", byte_is_high); end
    checks++; if (fifo_count !== 3'd0)  begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    step();
    rst_n = 1'b1; y_valid = 1'b0;
    step();
  endtask

  // One result with ack held high: checks latency, byte order and return to IDLE.
  task automatic test_single(input logic [DW-1:0] w);
    step();
    byte_ack = 1'b1;
    y_n = w; y_valid = 1'b1;
    expect_word(w);
    step();
    y_valid = 1'b0;
    @(negedge clk);
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b expected 0", byte_valid); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
    step();
    @(negedge clk);
    checks++;
    if ({byte_valid, byte_is_high} !== 2'b10) begin
      errors++; $display("FAIL single_latency: got valid=%0b hi=%0b expected valid=1 hi=0", byte_valid, byte_is_high);
    end
    step();
    @(negedge clk);
    checks++;
    if ({byte_valid, byte_is_high} !== 2'b11) begin
      errors++; $display("FAIL single_hi: got valid=%0b hi=%0b expected valid=1 hi=1", byte_valid, byte_is_high);
    end
    step();
    @(negedge clk);
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got valid=%0b expected 0", byte_valid); end
    wait_drain();
  endtask

  task automatic test_backpressure();
    step();
    byte_ack = 1'b0;
    y_n = 14'h2A5C; y_valid = 1'b1;
    expect_word(14'h2A5C);
    step();
    y_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({byte_valid, byte_is_high, byte_out} !== {1'b1, 1'b0, 8'h5C}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%0b hi=%0b byte=%02h expected valid=1 hi=0 byte=5c",
                 i, byte_valid, byte_is_high, byte_out);
      end
      step();
    end
    byte_ack = 1'b1;
    wait_drain();
  endtask

  task automatic test_overflow();
    logic [DW-1:0] w[6];
    logic [DW-1:0] extra;
    step();
    byte_ack = 1'b0; ovf_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w[i] = DW'($urandom);
      y_n = w[i]; y_valid = 1'b1;
      if (i < 5) expect_word(w[i]);
      step();
    end
    y_valid = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
    checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL ovf_set: got %0b expected 1", overflow); end
    checks++;
    if ({byte_valid, byte_out} !== {1'b1, w[0][7:0]}) begin
      errors++; $display("FAIL ovf_head: got valid=%0b byte=%02h expected valid=1 byte=%02h", byte_valid, byte_out, w[0][7:0]);
    end
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b expected 0", overflow); end
    step();
    ovf_clr = 1'b1; y_valid = 1'b1; y_n = DW'($urandom);
    step();
    ovf_clr = 1'b0; y_valid = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL ovf_set_wins: got %0b expected 1", overflow); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count_after_drop: got %0d expected 4", fifo_count); end
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    // low byte of the head goes out, then a push lands on the full FIFO
    // at the same edge as the high-byte transfer pops the next word
    step();
    byte_ack = 1'b1;
    step();
    extra = DW'($urandom);
    y_n = extra; y_valid = 1'b1;
    expect_word(extra);
    step();
    y_valid = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_push_pop_count: got %0d expected 4", fifo_count); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL full_push_pop_ovf: got %0b expected 0", overflow); end
    wait_drain();
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] r[3];
    step();
    byte_ack = 1'b1;
    for (int k = 0; k < 3; k++) r[k] = DW'($urandom);
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || i == 2 || i == 4) begin
        y_n = r[i/2]; y_valid = 1'b1;
        expect_word(r[i/2]);
      end
      step();
      y_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (i >= 1 && i <= 6) begin
        if ({byte_valid, byte_is_high} !== {1'b1, (i % 2 == 0)}) begin
          errors++;
          $display("FAIL stream_cycle[%0d]: got valid=%0b hi=%0b expected valid=1 hi=%0b",
                   i, byte_valid, byte_is_high, (i % 2 == 0));
        end
      end else if (i == 7) begin
        if (byte_valid !== 1'b0) begin
          errors++; $display("FAIL stream_end: got valid=%0b expected 0", byte_valid);
        end
      end else if (byte_valid !== 1'b0) begin
        errors++; $display("FAIL stream_start: got valid=%0b expected 0", byte_valid);
      end
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    step();
    byte_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      y_n = DW'($urandom); y_valid = 1'b1;
      expect_word(y_n);
      step();
    end
    y_valid = 1'b0; byte_ack = 1'b1;
    step();
    byte_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_valid, byte_is_high, fifo_count} !== {1'b1, 1'b1, 3'd2}) begin
      errors++; $display("FAIL mid_setup: got valid=%0b hi=%0b count=%0d expected 1 1 2", byte_valid, byte_is_high, fifo_count);
    end
    step();
    rst_n = 1'b0; y_valid = 1'b1; y_n = DW'($urandom);
    exp_q.delete();
    step();
    @(negedge clk);
    checks++;
    if ({byte_out, byte_valid, byte_is_high, fifo_count, overflow} !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset: got byte=%02h valid=%0b hi=%0b count=%0d ovf=%0b expected all 0",
               byte_out, byte_valid, byte_is_high, fifo_count, overflow);
    end
    step();
    rst_n = 1'b1; y_valid = 1'b0; byte_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (byte_valid !== 1'b0 || fifo_count !== 3'd0) begin
        errors++; $display("FAIL mid_stale[%0d]: got valid=%0b count=%0d expected 0 0", i, byte_valid, fifo_count);
      end
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; y_valid = 1'b0; y_n = '0; byte_ack = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_single(14'h2A5C);
    test_single(14'h0123);
    test_backpressure();
    test_overflow();
    test_streaming();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover_bytes: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
